// File: rtl/packet_flit_sender_if.sv
// Shared flit/packet types and the handshake bundle between the packet buffer,
// the flit sender and the downstream flit sink.

package types;
  typedef enum logic [1:0] {
    HEAD    = 2'd0,
    BODY    = 2'd1,
    TAIL    = 2'd2,
    INVALID = 2'd3
  } flittype_t;

  typedef struct packed {
    flittype_t   flittype;
    logic [3:0]  dest;
    logic [1:0]  vc;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
  } flit_t;
endpackage

package packet_types;
  localparam int PACKET_MAX_FLITS = 8;
  // One spare bit so out-of-range tail indices are representable.
  localparam int TAIL_W = $clog2(PACKET_MAX_FLITS) + 1;

  typedef struct packed {
    types::flit_t [PACKET_MAX_FLITS-1:0] buffer;
    logic [TAIL_W-1:0]                   tail_index;
    logic                                is_complete;
    logic [15:0]                         timer;
    logic [7:0]                          packet_id;
  } packet_element_t;
endpackage

interface packet_flit_sender_if;
  packet_types::packet_element_t transfered_packet;
  logic                          transfered_packet_valid;
  logic                          transfered_packet_completed;
  types::flit_t                  out_flit;
  logic                          out_flit_valid;
  logic                          out_flit_ready;

  // Environment side: offers entries, consumes flits.
  modport master (
    output transfered_packet,
    output transfered_packet_valid,
    input  transfered_packet_completed,
    input  out_flit,
    input  out_flit_valid,
    output out_flit_ready
  );

  // Sender side.
  modport slave (
    input  transfered_packet,
    input  transfered_packet_valid,
    output transfered_packet_completed,
    output out_flit,
    output out_flit_valid,
    input  out_flit_ready
  );
endinterface

// File: rtl/packet_flit_sender.sv
// Pops completed packet entries, snapshots them and serializes the flits
// head-first onto a valid/ready stream; malformed entries are dropped and counted.

module packet_flit_sender #(
  parameter int PACKET_MAX_FLITS = 8,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 nocclk,
  input  logic                 rst_n,
  packet_flit_sender_if.slave  bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_packet_count,
  output logic [7:0]           dropped_packet_count
);

  localparam int IDX_W = (PACKET_MAX_FLITS > 1) ? $clog2(PACKET_MAX_FLITS) : 1;
  localparam int NUM_W = $clog2(PACKET_MAX_FLITS + 1);
  localparam int TI_W  = packet_types::TAIL_W;
  localparam logic [TI_W-1:0] MAX_TI = TI_W'(PACKET_MAX_FLITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [IDX_W-1:0]              flit_idx_q, flit_idx_d;
  logic [NUM_W-1:0]              num_flits_q, num_flits_d;
  logic [CNT_WIDTH-1:0]          sent_q, sent_d;
  logic [7:0]                    drop_q, drop_d;
  packet_types::packet_element_t snap_q;
  logic                          capture;

  logic [TI_W-1:0]  tail;
  logic [IDX_W-1:0] last_pos;
  logic             tail_ok;
  logic             well_formed;
  logic             last_flit;

  // Well-formedness of the entry currently offered upstream.
  always_comb begin
    tail     = bus.transfered_packet.tail_index;
    tail_ok  = (tail != '0) && (tail <= MAX_TI);
    last_pos = IDX_W'(tail - TI_W'(1));
    well_formed = tail_ok
               && (bus.transfered_packet.buffer[0].header.flittype == types::HEAD)
               && bus.transfered_packet.is_complete
               && ((tail == TI_W'(1))
                   || (bus.transfered_packet.buffer[last_pos].header.flittype == types::TAIL));
  end

  assign last_flit = (NUM_W'(flit_idx_q) == (num_flits_q - NUM_W'(1)));

  // Next-state logic for the IDLE/SEND controller and both counters.
  always_comb begin
    state_d     = state_q;
    flit_idx_d  = flit_idx_q;
    num_flits_d = num_flits_q;
    sent_d      = sent_q;
    drop_d      = drop_q;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.transfered_packet_valid) begin
          if (well_formed) begin
            capture     = 1'b1;
            state_d     = SEND;
            flit_idx_d  = '0;
            num_flits_d = NUM_W'(tail);
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      SEND: begin
        if (bus.out_flit_ready) begin
          if (last_flit) begin
            state_d = IDLE;
            sent_d  = sent_q + CNT_WIDTH'(1);
          end else begin
            flit_idx_d = flit_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and counter registers with synchronous active-low reset.
  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flit_idx_q  <= '0;
      num_flits_q <= '0;
      sent_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      flit_idx_q  <= flit_idx_d;
      num_flits_q <= num_flits_d;
      sent_q      <= sent_d;
      drop_q      <= drop_d;
    end
  end

  // Snapshot of the accepted entry; contents are don't-care outside SEND.
  always_ff @(posedge nocclk) begin
    if (capture) snap_q <= bus.transfered_packet;
  end

  // Metadata is carried in the snapshot but never interpreted here.
  logic unused_meta;
  assign unused_meta = ^{snap_q.tail_index, snap_q.is_complete, snap_q.timer, snap_q.packet_id};

  // Pop is suppressed during reset so no entry is released and then lost.
  assign bus.transfered_packet_completed = rst_n && (state_q == IDLE) && bus.transfered_packet_valid;
  assign bus.out_flit_valid = (state_q == SEND);
  assign bus.out_flit       = snap_q.buffer[flit_idx_q];
  assign busy               = (state_q == SEND);
  assign sent_packet_count    = sent_q;
  assign dropped_packet_count = drop_q;

endmodule

// File: doc/packet_flit_sender.md
# packet_flit_sender

Downstream stage of the packet buffer. Pops one completed packet entry (`packet_types::packet_element_t`) at a time and snapshots it locally. It releases the upstream entry in the same cycle, then serializes the stored flits, head first, onto a valid/ready flit stream toward the router/transmit path. Malformed entries are dropped and counted.

## Interface
- `PACKET_MAX_FLITS`, default 8: depth of `packet_element_t.buffer`; must match packet_types.
- `CNT_WIDTH`, default 16: width of the sent-packet counter.
- `nocclk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low (sampled on posedge `nocclk`).
- `transfered_packet`  in  packet_element_t  completed entry from the packet buffer.
- `transfered_packet_valid`  in  1  entry available.
- `transfered_packet_completed`  out  1  pop/release pulse; doubles as ready.
- `out_flit`  out  types::flit_t  flit being offered.
- `out_flit_valid`  out  1  `out_flit` valid.
- `out_flit_ready`  in  1  sink accepts.
- `busy`  out  1  a packet is being serialized.
- `sent_packet_count`  out  CNT_WIDTH  packets fully sent; wraps.
- `dropped_packet_count`  out  8  malformed entries dropped; saturates at 255.

## Operation
- Local state: snapshot register (full element), `flit_idx` ($clog2(PACKET_MAX_FLITS) bits), `num_flits` ($clog2(PACKET_MAX_FLITS+1) bits), FSM {IDLE, SEND}.
- An entry is well-formed when all of these hold:
  - `1 <= tail_index <= PACKET_MAX_FLITS`.
  - `buffer[0].header.flittype == HEAD`.
  - `buffer[tail_index-1].header.flittype == TAIL`, or `tail_index == 1` with a HEAD flit.
  - `is_complete == 1`.
- IDLE, `transfered_packet_valid == 1`:
  - `transfered_packet_completed` is driven 1 combinationally in that cycle.
  - Well-formed entry: capture the snapshot, set `num_flits = tail_index`, clear `flit_idx`, go to SEND.
  - Malformed entry: increment the drop count (saturating) and stay in IDLE.
- IDLE, no valid: `transfered_packet_completed = 0` and `out_flit_valid = 0`.
- SEND:
  - `out_flit_valid = 1` and `out_flit = snapshot.buffer[flit_idx]`. Output is held stable until accepted.
  - `out_flit_valid & out_flit_ready` with `flit_idx == num_flits-1`: increment `sent_packet_count` and go to IDLE.
  - Acceptance on any other flit: `flit_idx++`.
  - `transfered_packet_completed = 0` throughout SEND. The upstream is not popped again until IDLE.
- `busy = (state == SEND)`.
- `transfered_packet_completed` is never 1 while `transfered_packet_valid == 0`.
- Flit contents are forwarded unmodified. `timer` and `packet_id` are not interpreted beyond the snapshot.

## Timing
- Reset (`rst_n == 0` at a posedge):
  - State goes to IDLE; `flit_idx = 0`; both counters = 0.
  - Outputs: `out_flit_valid = 0`, `busy = 0`, `transfered_packet_completed = 0`.
  - Snapshot contents are don't-care.
  - Reset asserted mid-SEND abandons the packet with no count change. The upstream entry was already released at capture.
- Latency:
  - Capture and release in cycle N; flit 0 valid in cycle N+1.
  - With ready held high, a k-flit packet occupies cycles N+1..N+k.
- Back-to-back packets:
  - Last flit accepted in cycle M, IDLE in M+1, next capture in M+1, next flit 0 in M+2.
  - Minimum one idle output cycle between packets.
- Backpressure: `out_flit_ready == 0` holds `out_flit` and `flit_idx` unchanged indefinitely. No timeout.
- Simultaneous events:
  - An upstream valid arriving during SEND is ignored until IDLE.
  - A valid/ready on the last flit in the same cycle as a new upstream valid does not capture until the next cycle.
- Counter rules:
  - `sent_packet_count` wraps from 2^CNT_WIDTH-1 to 0.
  - `dropped_packet_count` stays at 255.

## Test plan
- Reset: hold `rst_n = 0` for 3 cycles while `transfered_packet_valid = 1` -> `completed = 0`, `out_flit_valid = 0`, counters 0 throughout.
- 3-flit packet (HEAD, BODY, TAIL; `tail_index = 3`), ready high:
  - `completed` pulses for 1 cycle at N.
  - Flits appear at N+1..N+3 in order, bit-identical.
  - `sent_packet_count = 1`; `busy` high for exactly 3 cycles.
- Backpressure on the 3-flit packet, ready pattern 1,0,0,1,1 -> BODY held for 3 cycles unchanged; TAIL accepted on the 5th cycle; count 1.
- Malformed entries:
  - `tail_index = 0` -> `completed` pulses and nothing is emitted.
  - `tail_index = PACKET_MAX_FLITS+1` -> same.
  - `buffer[0]` BODY -> same.
  - After the three, `dropped_packet_count = 3` and `sent_packet_count` is unchanged.
- Back-to-back: upstream valid held with a 1-flit HEAD packet and then a 2-flit packet -> flits at N+1, N+3, N+4; exactly two `completed` pulses, at N and N+2.
- Reset mid-SEND: assert `rst_n = 0` after flit 1 of 4 -> `out_flit_valid = 0` next cycle, count unchanged; a subsequent packet sends normally starting from flit 0.
